// File: rtl/cbus_mem_responder_pkg.sv
// cbus_mem_responder_pkg: shared cbus request/response types used by the memory responder and its address generator
// Exports: msize_t, mlen_t, burst_t, cbus_req_t, cbus_resp_t, CBUS_AW
package cbus_mem_responder_pkg;

    localparam int CBUS_AW = 32;

    typedef logic [2:0] msize_t;
    typedef logic [3:0] mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_t;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        msize_t             size;
        logic [CBUS_AW-1:0] addr;
        logic [7:0]         strobe;
        logic [63:0]        data;
        mlen_t              len;
        burst_t             burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_mem_responder_addr_gen.sv
// cbus_burst_addr_gen: combinational next-beat address for FIXED, INCR and WRAP bursts
// Ports: addr (current beat address), len (beats-1), burst (type) -> next_addr
module cbus_burst_addr_gen
    import cbus_mem_responder_pkg::*;
(
    input  logic [CBUS_AW-1:0] addr,
    input  mlen_t              len,
    input  burst_t             burst,
    output logic [CBUS_AW-1:0] next_addr
);

    logic [CBUS_AW-1:0] incr;
    logic [CBUS_AW-1:0] wrap_mask;

    // WRAP keeps the bits above the (len+1)*8-byte block and lets only the offset inside it roll over
    assign incr      = addr + CBUS_AW'(8);
    assign wrap_mask = ((CBUS_AW'(len) + CBUS_AW'(1)) << 3) - CBUS_AW'(1);
    assign next_addr = burst == BURST_FIXED ? addr :
                       burst == BURST_WRAP  ? (addr & ~wrap_mask) | (incr & wrap_mask) : incr;

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: cbus slave backed by a 64-bit word array with fixed access latency and FIXED/INCR/WRAP bursts
// Ports: clk, reset (sync, active-low), creq (request from initiator), cresp (ready/last/read data per beat)
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t             state, state_nx;
    logic [CBUS_AW-1:0] addr_q, addr_nx;
    mlen_t              len_q, beat_cnt;
    burst_t             burst_q;
    logic               wr_q;
    logic [3:0]         wait_cnt;
    logic               beat, last, in_range;
    logic [AW-1:0]      idx;
    logic [63:0]        mem [MEM_WORDS];
    logic               unused;

    cbus_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nx)
    );

    // a beat only happens while the initiator still holds valid, so a dropped valid kills ready and writes at once
    assign beat     = state == BURST && creq.valid;
    assign last     = beat && beat_cnt == len_q;
    assign idx      = addr_q[AW+2:3];
    assign in_range = addr_q[CBUS_AW-1:AW+3] == '0;
    assign unused   = ^creq.size;

    assign cresp.ready = beat;
    assign cresp.last  = last;
    assign cresp.data  = beat && !wr_q && in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            wr_q     <= 1'b0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && creq.valid) begin
                addr_q   <= creq.addr;
                len_q    <= creq.len;
                burst_q  <= creq.burst;
                wr_q     <= creq.is_write;
                beat_cnt <= '0;
                wait_cnt <= '0;
            end
            if (state == WAIT)
                wait_cnt <= wait_cnt + 4'd1;
            if (beat) begin
                addr_q   <= addr_nx;
                beat_cnt <= beat_cnt + mlen_t'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !creq.valid ? IDLE : LATENCY == 0 ? BURST : WAIT;
            WAIT:    state_nx = !creq.valid ? IDLE : wait_cnt == WAIT_LAST ? BURST : WAIT;
            BURST:   state_nx = !creq.valid || last ? IDLE : BURST;
            default: state_nx = IDLE;
        endcase
    end

    // contents survive reset; a write arriving on a reset edge is dropped along with the burst
    always_ff @(posedge clk) begin
        if (reset && beat && wr_q && in_range)
            for (int i = 0; i < 8; i++)
                if (creq.strobe[i])
                    mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed self-checking bench for cbus_mem_responder
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    logic [63:0] wdat [16];
    logic [7:0]  wstb [16];
    logic [63:0] rdat [16];
    logic        lastv [16];
    int          ready_cyc [16];
    logic [63:0] expd [16];
    logic [63:0] model [16];
    int          nbeats;
    int          n_chk = 0;
    int          n_pass = 0;

    cbus_mem_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // mode 0: plain burst; mode 1: pull reset during beat ab; mode 2: drop valid after beat ab
    task automatic xfer(input logic wr, input burst_t b, input logic [31:0] a, input mlen_t l,
                        input int mode, input int ab, input logic hold);
        int  k, cyc;
        logic seen;
        k = 0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            rdat[i] = '0;
            lastv[i] = 1'b0;
            ready_cyc[i] = -1;
        end
        creq.valid = 1'b1;
        creq.is_write = wr;
        creq.burst = b;
        creq.addr = a;
        creq.len = l;
        creq.size = 3'd3;
        creq.data = wdat[0];
        creq.strobe = wstb[0];
        while (k <= int'(l) && cyc < 64) begin
            @(negedge clk);
            seen = cresp.ready;
            if (seen) begin
                rdat[k] = cresp.data;
                lastv[k] = cresp.last;
                ready_cyc[k] = cyc;
            end
            if (mode == 1 && seen && k == ab) begin
                reset = 1'b0;
                creq.valid = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
                @(negedge clk);
                check("rst_cresp", cresp, '0);
                nbeats = k;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (seen) begin
                k++;
                if (k < 16) begin
                    creq.data = wdat[k];
                    creq.strobe = wstb[k];
                end
            end
            if (mode == 2 && seen && k - 1 == ab) begin
                creq.valid = 1'b0;
                @(negedge clk);
                check("abort_ready", 66'(cresp.ready), 66'(0));
                @(posedge clk);
                #1;
                @(negedge clk);
                check("abort_cresp", cresp, '0);
                nbeats = k;
                @(posedge clk);
                #1;
                return;
            end
        end
        nbeats = k;
        if (!hold)
            creq.valid = 1'b0;
    endtask

    task automatic chk_read(input string tag, input int n, input int skip);
        check({tag, "_beats"}, 66'(nbeats), 66'(n));
        for (int i = 0; i < n; i++)
            if (i != skip) begin
                check($sformatf("%s_d%0d", tag, i), 66'(rdat[i]), 66'(expd[i]));
                check($sformatf("%s_l%0d", tag, i), 66'(lastv[i]), 66'(i == n - 1));
            end
    endtask

    initial begin
        creq = '0;
        for (int i = 0; i < 16; i++) begin
            model[i] = i == 0 ? 64'h0 : {16'hBEEF, 16'(i), 32'h1234_5678 + 32'(i)};
            wstb[i] = 8'hFF;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_cresp", cresp, '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            wdat[i] = model[i];
            expd[i] = '0;
        end
        xfer(1'b1, BURST_INCR, 32'h0, 4'd15, 0, 0, 1'b0);
        chk_read("preload", 16, -1);

        xfer(1'b0, BURST_INCR, 32'h40, 4'd3, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) expd[i] = model[8 + i];
        chk_read("incr", 4, -1);
        for (int i = 0; i < 4; i++)
            check($sformatf("incr_cyc%0d", i), 66'(ready_cyc[i]), 66'(3 + i));

        wdat[0] = 64'h1122334455667788;
        wdat[1] = 64'h1122334455667788;
        wstb[0] = 8'h0F;
        wstb[1] = 8'hFF;
        xfer(1'b1, BURST_INCR, 32'h0, 4'd1, 0, 0, 1'b0);
        wstb[0] = 8'hFF;
        model[0] = 64'h0000000055667788;
        model[1] = 64'h1122334455667788;
        xfer(1'b0, BURST_INCR, 32'h0, 4'd1, 0, 0, 1'b0);
        expd[0] = 64'h0000000055667788;
        expd[1] = 64'h1122334455667788;
        chk_read("strobe", 2, -1);

        xfer(1'b0, BURST_WRAP, 32'h18, 4'd3, 0, 0, 1'b0);
        expd[0] = model[3];
        expd[1] = model[0];
        expd[2] = model[1];
        expd[3] = model[2];
        chk_read("wrap", 4, -1);

        xfer(1'b0, BURST_FIXED, 32'h8, 4'd2, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) expd[i] = model[1];
        chk_read("fixed", 3, -1);

        for (int i = 0; i < 16; i++) wdat[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        xfer(1'b1, BURST_INCR, 32'h20, 4'd7, 1, 2, 1'b0);
        check("rst_beats", 66'(nbeats), 66'(2));
        model[4] = wdat[0];
        model[5] = wdat[1];
        xfer(1'b0, BURST_INCR, 32'h20, 4'd7, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) expd[i] = model[4 + i];
        chk_read("rst_after", 8, 2);
        check("rst_after_cyc", 66'(ready_cyc[0]), 66'(3));

        for (int i = 0; i < 16; i++) wdat[i] = 64'hFACE_0000_0000_0000 | 64'(i);
        xfer(1'b1, BURST_INCR, 32'h60, 4'd3, 2, 1, 1'b0);
        model[12] = wdat[0];
        model[13] = wdat[1];
        xfer(1'b0, BURST_INCR, 32'h60, 4'd3, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) expd[i] = model[12 + i];
        chk_read("abort_after", 4, -1);

        xfer(1'b0, BURST_INCR, 32'h40, 4'd0, 0, 0, 1'b1);
        expd[0] = model[8];
        chk_read("b2b_first", 1, -1);
        xfer(1'b0, BURST_INCR, 32'h2000, 4'd1, 0, 0, 1'b0);
        expd[0] = '0;
        expd[1] = '0;
        chk_read("b2b_oor", 2, -1);
        check("b2b_cyc0", 66'(ready_cyc[0]), 66'(3));
        check("b2b_cyc1", 66'(ready_cyc[1]), 66'(4));

        wdat[0] = '1;
        xfer(1'b1, BURST_FIXED, 32'h2000, 4'd0, 0, 0, 1'b0);
        check("oor_wr_beats", 66'(nbeats), 66'(1));
        xfer(1'b0, BURST_INCR, 32'h0, 4'd0, 0, 0, 1'b0);
        expd[0] = model[0];
        chk_read("oor_drop", 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cbus_mem_responder.md
CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, 1024, number of 64-bit words in the backing array (power of 2).
REQ-002 SHALL have parameter LATENCY, 2, idle cycles between request acceptance and the first data beat (0..15).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port creq, input, cbus_req_t: valid, is_write, size, addr, strobe, data, len, burst.
REQ-006 SHALL have port cresp, output, cbus_resp_t: ready, last, data.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT and BURST; IDLE SHALL be the reset state.
REQ-008 In IDLE with creq.valid=1, SHALL latch addr, len, burst and is_write, clear beat counter and go to WAIT (or to BURST if LATENCY=0).
REQ-009 WAIT SHALL count LATENCY cycles and then go to BURST; cresp SHALL stay all-zero in WAIT.
REQ-010 In BURST, SHALL assert cresp.ready for exactly one cycle per beat, one beat per cycle, len+1 beats in total.
REQ-011 SHALL assert cresp.last together with ready on the beat where the beat counter equals the latched len, then go to IDLE.
REQ-012 After last, SHALL spend at least one cycle in IDLE before accepting a new request.
REQ-013 Beat word index SHALL be beat_addr[$clog2(MEM_WORDS)+2:3]; byte lanes below bit 3 SHALL be ignored for indexing.
REQ-014 burst FIXED: every beat SHALL use the latched address.
REQ-015 burst INCR: beat_addr SHALL advance by 8 per beat.
REQ-016 burst WRAP: beat_addr SHALL advance by 8 and wrap within the aligned block of (len+1)*8 bytes; len+1 SHALL be 1, 2, 4, 8 or 16.
REQ-017 Read beat: cresp.data SHALL equal mem[word index] as of that cycle, combinationally from the registered index.
REQ-018 Write beat: SHALL update byte i of mem[word index] with creq.data byte i wherever creq.strobe[i]=1; cresp.data SHALL be 0.
REQ-019 The initiator presents the next write-beat data in the cycle after each ready; data SHALL be sampled only in ready cycles.
REQ-020 Addresses at or beyond MEM_WORDS*8 SHALL read as 0 and drop writes; the burst SHALL still complete with normal ready/last timing.
REQ-021 If creq.valid falls in WAIT or BURST, SHALL abort to IDLE on the next edge with no further ready and no further writes.
REQ-022 Outside BURST, cresp SHALL be all-zero.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE, clear the counters and the latched request, and zero cresp, including mid-burst.
REQ-024 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-025 cbus_req_t, cbus_resp_t, msize_t, mlen_t and the burst-type enum SHALL come from the shared pipes/common packages; no local redefinitions.
REQ-026 The FSM state enum SHALL be local to the module.
REQ-027 Next-address computation (FIXED/INCR/WRAP) SHALL be a single sub-module, cbus_burst_addr_gen: current addr, len and burst in; next addr out; purely combinational.

Verification
REQ-028 LATENCY=2, read INCR addr 0x40, len=3, mem[8..11]=A,B,C,D -> ready on cycles 3..6 after acceptance, data A,B,C,D, last on cycle 6 only.
REQ-029 Write INCR addr 0x0, len=1, strobe 0x0F then 0xFF, data 0x1122334455667788 both beats -> mem[0]=0x0000000055667788, mem[1]=0x1122334455667788.
REQ-030 Read WRAP addr 0x18, len=3 -> beat word indices 3,0,1,2, last on the 4th beat.
REQ-031 Read FIXED addr 0x8, len=2 -> three beats, all returning mem[1].
REQ-032 reset=0 during beat 2 of a len=7 write -> cresp=0 the next cycle, FSM in IDLE, beats 3..7 never written, earlier-written words retained.
REQ-033 Back-to-back requests, valid held high across last -> exactly one IDLE cycle, second request accepted on the following cycle; addr 0x2000 with MEM_WORDS=1024 -> reads 0, completes normally.
